// File: rtl/proc_debug_pkg.sv
// Shared types and constants for the processor run-control / display front end.
// Holds the run-control state encoding, the hex glyph table and counter width helpers.
package proc_debug_pkg;

  typedef enum logic [1:0] {
    INSPECT = 2'd0,
    RUN     = 2'd1,
    HALT    = 2'd2,
    STEP    = 2'd3
  } dbg_state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module ssd_hex_decoder
  import proc_debug_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/proc_debug_controller.sv
// Run-control state machine (inspect / run / breakpoint halt / single step), step-button
// debounce, register-file port-1 steering and multiplexed hex display on a single clock.
module proc_debug_controller
  import proc_debug_pkg::*;
#(
  parameter int DIV_RUN  = 5_000_000,
  parameter int SCAN_DIV = 10_000,
  parameter int DEBOUNCE = 50_000,
  parameter int DIGITS   = 4,
  parameter int PC_W     = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clkFast,
  input  logic              reset,
  input  logic              switchRun,
  input  logic              btnStep,
  input  logic [4:0]        SwitchSelector,
  input  logic              bpEnable,
  input  logic [PC_W-1:0]   bpAddr,
  input  logic [PC_W-1:0]   PC_out,
  input  logic [4:0]        instr_rs,
  input  logic [DATA_W-1:0] reg_read_data_1,
  output logic              cpu_en,
  output logic [4:0]        rf_read_addr,
  output logic              rf_we_allow,
  output logic              halted,
  output logic              LEDIndicator,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        Cathode
);

  localparam int DIV_W  = cnt_w(DIV_RUN);
  localparam int SCAN_W = cnt_w(SCAN_DIV);
  localparam int DB_W   = cnt_w(DEBOUNCE);
  localparam int DIG_W  = cnt_w(DIGITS);
  localparam int VAL_W  = 4 * DIGITS;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_RUN - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

  dbg_state_t state, state_next;

  logic              sync_q1, sync_q2;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic              step_evt;
  logic              step_from_halt;
  logic [DIV_W-1:0]  div_cnt;
  logic              bp_armed;
  logic              run_due;
  logic              run_pulse;
  logic              en_next;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DIG_W-1:0]  digit, digit_next;
  logic [VAL_W-1:0]  disp_val;
  logic [PC_W+VAL_W-1:0] pc_ext;
  logic [3:0]        nibble;
  logic              unused_bits;

  // Step button: two-flop synchroniser, then a level that only flips after DEBOUNCE
  // stable cycles. step_evt fires once on the accepted low-to-high flip.
  always_ff @(posedge clkFast) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      step_evt <= 1'b0;
    end else begin
      sync_q1  <= btnStep;
      sync_q2  <= sync_q1;
      step_evt <= 1'b0;
      if (sync_q2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sync_q2;
          db_cnt   <= '0;
          step_evt <= sync_q2;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Next-state logic. A due pulse that lands on an armed breakpoint is swallowed.
  always_comb begin
    state_next = state;
    run_pulse  = 1'b0;
    run_due    = (state == RUN) && (div_cnt == DIV_LAST);
    case (state)
      INSPECT: begin
        if (switchRun)     state_next = RUN;
        else if (step_evt) state_next = STEP;
      end
      RUN: begin
        if (!switchRun) begin
          state_next = INSPECT;
        end else if (run_due) begin
          if (bpEnable && bp_armed && (PC_out == bpAddr)) state_next = HALT;
          else                                            run_pulse  = 1'b1;
        end
      end
      HALT: begin
        if (!switchRun)    state_next = INSPECT;
        else if (step_evt) state_next = STEP;
      end
      STEP: begin
        state_next = step_from_halt ? HALT : INSPECT;
      end
      default: state_next = INSPECT;
    endcase
    en_next = run_pulse || (state_next == STEP);
  end

  always_ff @(posedge clkFast) begin
    if (reset) begin
      state          <= INSPECT;
      cpu_en         <= 1'b0;
      halted         <= 1'b0;
      LEDIndicator   <= 1'b0;
      step_from_halt <= 1'b0;
      div_cnt        <= '0;
      bp_armed       <= 1'b0;
    end else begin
      state        <= state_next;
      cpu_en       <= en_next;
      halted       <= (state_next == HALT);
      LEDIndicator <= LEDIndicator ^ en_next;
      if (state_next == STEP) step_from_halt <= (state == HALT);
      // Divider only runs while staying in RUN, so every entry restarts from zero.
      if ((state == RUN) && (state_next == RUN))
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;
      if (state != RUN)   bp_armed <= 1'b0;
      else if (run_pulse) bp_armed <= 1'b1;
    end
  end

  assign rf_read_addr = (state == INSPECT) ? SwitchSelector : instr_rs;
  assign rf_we_allow  = (state != INSPECT);

  // Display scan: digit index and anodes advance together so the glyph mux never lags.
  always_comb begin
    digit_next = (digit == DIG_LAST) ? '0 : digit + 1'b1;
  end

  always_ff @(posedge clkFast) begin
    if (reset) begin
      scan_cnt <= '0;
      digit    <= '0;
      AN       <= ~DIGITS'(1);
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit_next;
      AN       <= ~(DIGITS'(1) << digit_next);
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign pc_ext   = {{VAL_W{1'b0}}, PC_out};
  assign disp_val = switchRun ? pc_ext[VAL_W-1:0] : reg_read_data_1[VAL_W-1:0];

  always_comb begin
    nibble = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit == DIG_W'(k)) nibble = disp_val[4*k +: 4];
    end
  end

  ssd_hex_decoder u_hex (
    .nibble   (nibble),
    .segments (Cathode)
  );

  assign unused_bits = ^{reg_read_data_1, pc_ext};

endmodule

// File: tb/tb_proc_debug_controller.sv
// Directed bench for proc_debug_controller with small divider/scan/debounce settings.
module tb_proc_debug_controller;

  logic        clkFast;
  logic        reset;
  logic        switchRun;
  logic        btnStep;
  logic [4:0]  SwitchSelector;
  logic        bpEnable;
  logic [7:0]  bpAddr;
  logic [7:0]  PC_out;
  logic [4:0]  instr_rs;
  logic [31:0] reg_read_data_1;
  logic        cpu_en;
  logic [4:0]  rf_read_addr;
  logic        rf_we_allow;
  logic        halted;
  logic        LEDIndicator;
  logic [3:0]  AN;
  logic [6:0]  Cathode;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  logic exp_led = 1'b0;

  proc_debug_controller #(
    .DIV_RUN (4),
    .SCAN_DIV(2),
    .DEBOUNCE(3),
    .DIGITS  (4),
    .PC_W    (8),
    .DATA_W  (32)
  ) dut (
    .clkFast        (clkFast),
    .reset          (reset),
    .switchRun      (switchRun),
    .btnStep        (btnStep),
    .SwitchSelector (SwitchSelector),
    .bpEnable       (bpEnable),
    .bpAddr         (bpAddr),
    .PC_out         (PC_out),
    .instr_rs       (instr_rs),
    .reg_read_data_1(reg_read_data_1),
    .cpu_en         (cpu_en),
    .rf_read_addr   (rf_read_addr),
    .rf_we_allow    (rf_we_allow),
    .halted         (halted),
    .LEDIndicator   (LEDIndicator),
    .AN             (AN),
    .Cathode        (Cathode)
  );

  // Clock / reset
  initial clkFast = 1'b0;
  always #5 clkFast = ~clkFast;

  task automatic tick();
    @(posedge clkFast);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_en) pulse_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_an  [9] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
  logic [6:0] exp_cat [9] = '{7'h0E, 7'h0E, 7'h06, 7'h06, 7'h06, 7'h06, 7'h03, 7'h03, 7'h0E};

  initial begin
    reset = 1'b1; switchRun = 1'b0; btnStep = 1'b0; SwitchSelector = 5'd5;
    bpEnable = 1'b0; bpAddr = 8'h08; PC_out = 8'h00; instr_rs = 5'h11;
    reg_read_data_1 = 32'h0000_BEEF;
    repeat (3) tick();

    // Reset state
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_led", LEDIndicator, 1'b0);
    chk("rst_an", AN, 4'hE);
    chk("rst_cathode", Cathode, 7'h0E);
    chk("rst_we", rf_we_allow, 1'b0);
    chk("insp_addr", rf_read_addr, 5'd5);

    // Scan of 0xBEEF in INSPECT: F,E,E,B for two cycles each, then wrap
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("scan_an_%0d", i), AN, exp_an[i]);
      chk($sformatf("scan_cat_%0d", i), Cathode, exp_cat[i]);
      tick();
    end

    // Single step from INSPECT: pulse 6 cycles after the press, never repeats while held
    btnStep = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 6) begin
        exp_led = ~exp_led;
        chk("step_pulse", cpu_en, 1'b1);
        chk("step_addr", rf_read_addr, 5'h11);
        chk("step_we", rf_we_allow, 1'b1);
      end else begin
        chk($sformatf("step_idle_%0d", t), cpu_en, 1'b0);
      end
    end
    btnStep = 1'b0;
    pulse_cnt = 0;
    tick_n(8);
    chk("step_release_pulses", pulse_cnt, 0);
    chk("step_led", LEDIndicator, exp_led);

    // Bounces shorter than the debounce window produce nothing
    pulse_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      btnStep = 1'b1;
      tick_n(2);
      btnStep = 1'b0;
      tick_n(3);
    end
    tick_n(8);
    chk("bounce_pulses", pulse_cnt, 0);

    // Continuous run: pulses 4, 8, 12 cycles after entry
    switchRun = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 1) begin
        chk("run_we", rf_we_allow, 1'b1);
        chk("run_addr", rf_read_addr, 5'h11);
      end
      if (t == 5 || t == 9 || t == 13) begin
        exp_led = ~exp_led;
        chk($sformatf("run_pulse_%0d", t), cpu_en, 1'b1);
        chk($sformatf("run_led_%0d", t), LEDIndicator, exp_led);
      end else begin
        chk($sformatf("run_idle_%0d", t), cpu_en, 1'b0);
      end
    end

    // Breakpoint: pulse at PC=0x04, then halt instead of pulsing at PC=0x08
    bpEnable = 1'b1;
    PC_out = 8'h04;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk($sformatf("bp_pre_%0d", t), cpu_en, (t == 4));
    end
    exp_led = ~exp_led;
    PC_out = 8'h08;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk($sformatf("bp_en_%0d", t), cpu_en, 1'b0);
      chk($sformatf("bp_halted_%0d", t), halted, (t == 4));
    end
    tick();
    chk("halt_hold", halted, 1'b1);
    chk("halt_led", LEDIndicator, exp_led);

    // Step from HALT returns to HALT
    btnStep = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk($sformatf("hstep_en_%0d", t), cpu_en, (t == 6));
      chk($sformatf("hstep_halted_%0d", t), halted, (t != 6));
    end
    exp_led = ~exp_led;
    btnStep = 1'b0;
    pulse_cnt = 0;
    tick_n(8);
    chk("hstep_release_pulses", pulse_cnt, 0);
    chk("hstep_halted", halted, 1'b1);

    // Resume at the breakpoint PC: first pulse issues, the next due one halts
    switchRun = 1'b0;
    tick();
    chk("resume_insp_halted", halted, 1'b0);
    chk("resume_insp_we", rf_we_allow, 1'b0);
    switchRun = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk($sformatf("resume_en_%0d", t), cpu_en, (t == 5));
      chk($sformatf("resume_halted_%0d", t), halted, (t == 9));
    end
    exp_led = ~exp_led;
    chk("resume_led", LEDIndicator, exp_led);

    // Reset in the RUN cycle where a pulse is due
    switchRun = 1'b0;
    bpEnable = 1'b0;
    tick();
    switchRun = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    switchRun = 1'b0;
    tick();
    exp_led = 1'b0;
    chk("rrun_cpu_en", cpu_en, 1'b0);
    chk("rrun_halted", halted, 1'b0);
    chk("rrun_led", LEDIndicator, exp_led);
    chk("rrun_an", AN, 4'hE);
    chk("rrun_cathode", Cathode, 7'h0E);
    chk("rrun_we", rf_we_allow, 1'b0);
    reset = 1'b0;
    pulse_cnt = 0;
    tick_n(6);
    chk("rrun_after_pulses", pulse_cnt, 0);

    // Reset in the middle of a debounce discards the press
    btnStep = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    btnStep = 1'b0;
    tick();
    chk("rdb_cpu_en", cpu_en, 1'b0);
    reset = 1'b0;
    pulse_cnt = 0;
    tick_n(10);
    chk("rdb_after_pulses", pulse_cnt, 0);
    chk("rdb_led", LEDIndicator, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_debug_controller.md
# proc_debug_controller

Parametrised run-control and display front end for the single-cycle processor top. It replaces the free-running divided processor clock, the run/inspect mux and the fixed 4-digit scan with a state machine on one fast clock. Its outputs are:
- a one-cycle processor clock-enable pulse (`cpu_en`), generated in continuous-run or single-step mode;
- a PC breakpoint halt;
- register-file port-1 address and write-permission steering;
- an N-digit multiplexed hex seven-segment display.

It sits between the board I/O and the processor datapath, which clocks on clkFast and qualifies with `cpu_en`.

## Interface
Parameters:
- `DIV_RUN`, default 5_000_000: clkFast cycles between `cpu_en` pulses in RUN (≥2).
- `SCAN_DIV`, default 10_000: clkFast cycles per display digit (≥1).
- `DEBOUNCE`, default 50_000: cycles `btnStep` must be stable before it is accepted (≥1).
- `DIGITS`, default 4: number of display digits (1..8).
- `PC_W`, default 8: PC width.
- `DATA_W`, default 32: register data width (≥4*DIGITS).

Ports:
- `clkFast` in 1: the only clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `switchRun` in 1: 1 = run, 0 = inspect.
- `btnStep` in 1: raw single-step pushbutton, asynchronous. Synchronise it with 2 flip-flops.
- `SwitchSelector` in 5: register index to inspect.
- `bpEnable` in 1: breakpoint enable.
- `bpAddr` in PC_W: breakpoint PC.
- `PC_out` in PC_W: current processor PC.
- `instr_rs` in 5: `instruction[25:21]`.
- `reg_read_data_1` in DATA_W: register-file port-1 data.
- `cpu_en` out 1: one-cycle processor advance pulse.
- `rf_read_addr` out 5: register-file port-1 address.
- `rf_we_allow` out 1: AND this with the control unit's RegWrite.
- `halted` out 1: high in HALT.
- `LEDIndicator` out 1: toggles on every `cpu_en` pulse.
- `AN` out DIGITS: digit anodes, active-low, one-hot.
- `Cathode` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
States:

**INSPECT (reset state)**
- If `switchRun` = 1 → RUN.
- Else, on a debounced step press → STEP.

**RUN**
- If `switchRun` = 0 → INSPECT.
- The divider counts 0..DIV_RUN-1. `cpu_en` = 1 in the cycle the count equals DIV_RUN-1.
- If `bpEnable` && `bp_armed` && `PC_out` == `bpAddr` when a pulse is due: suppress the pulse and go to HALT.

**HALT**
- If `switchRun` = 0 → INSPECT.
- On a debounced step press → STEP.

**STEP**
- `cpu_en` = 1 for exactly one cycle.
- Then return to the state STEP was entered from (INSPECT or HALT).
- Breakpoints are ignored in STEP.

Breakpoint arming:
- `bp_armed` is cleared on every entry to RUN.
- It is set after the first pulse issued in RUN, so resuming from a breakpoint PC advances past it.

Register-file steering:
- `rf_read_addr` = `SwitchSelector` in INSPECT; `instr_rs` in all other states.
- `rf_we_allow` = 0 in INSPECT and 1 otherwise.
- In STEP, `instr_rs` drives the address and writes are allowed for the step cycle.

Step button:
- A press is accepted when the synchronised level has been stable high for DEBOUNCE cycles.
- Each press yields exactly one accepted event. The button must be seen stable low for DEBOUNCE cycles before it re-arms.
- A held button never repeats.

Display:
- The display value is `PC_out` zero-extended to 4*DIGITS bits when `switchRun` = 1, and `reg_read_data_1[4*DIGITS-1:0]` when `switchRun` = 0.
- Digit k shows nibble k. AN[0] is the rightmost digit and least significant nibble.
- The scan advances k → k+1 every SCAN_DIV cycles and wraps from DIGITS-1 to 0.
- Hex glyphs 0-F. Digit k's glyph comes from the current value and the current k, with no stale pipeline.

Reset values:
- state = INSPECT; `cpu_en` = 0; `halted` = 0; `LEDIndicator` = 0.
- Divider, scan and debounce counters = 0; `bp_armed` = 0.
- `AN` = all ones except AN[0] = 0. `Cathode` = glyph of the current nibble 0.
- Reset mid-pulse or mid-debounce discards the pending event.

## Timing
- All state, counters, `cpu_en`, `halted`, `LEDIndicator` and `AN` are registered.
- `rf_read_addr`, `rf_we_allow` and `Cathode` are combinational from registered state and the inputs.
- RUN entry → first `cpu_en` exactly DIV_RUN cycles later. Pulses follow every DIV_RUN cycles.
- `switchRun` falling → INSPECT next cycle. No pulse is issued in that cycle, and the divider resets.
- Step accepted at cycle t → STEP at t+1 (`cpu_en` high) → origin state at t+2.
- Step press and `switchRun` rising in the same cycle: `switchRun` wins (RUN). The press is dropped.
- Breakpoint compare uses `PC_out` in the due cycle. HALT is entered next cycle with `cpu_en` = 0.

## Structure
- Package `proc_debug_pkg` holds:
  - the state enum: INSPECT, RUN, HALT, STEP;
  - the hex-to-segment constant table (16×7, active-low);
  - the `$clog2` width helpers for the counters.
- One sub-module, `ssd_hex_decoder` (4-bit nibble → 7-bit active-low segments). It is combinational and instantiated once after the nibble mux.
- Debounce, divider and scan are plain counters inside the top.

## Test plan
Use DIV_RUN=4, SCAN_DIV=2, DEBOUNCE=3, DIGITS=4 throughout.
- Reset, then `switchRun`=1 → `cpu_en` pulses on cycles 4, 8, 12 after entry. `LEDIndicator` toggles each pulse. `rf_we_allow`=1.
- `switchRun`=0, `SwitchSelector`=5, `reg_read_data_1`=0x0000_BEEF → `rf_read_addr`=5 and `rf_we_allow`=0. The scan shows F,E,E,B on AN[0..3] in sequence, each for 2 cycles.
- INSPECT, `btnStep` high for 10 cycles → exactly one `cpu_en` pulse, 2 sync + 3 debounce + 1 cycles after the edge. `rf_read_addr`=`instr_rs` during the pulse. Bouncing shorter than 3 cycles yields no pulse.
- RUN, `bpEnable`=1, `bpAddr`=0x08, PC driven 0x04 then 0x08 → halt on the pulse due at PC=0x08 with no pulse. `halted`=1.
- From HALT: step → one pulse, stay in HALT. `switchRun` 0→1 with PC=0x08 → first pulse issued (not re-halted).
- Assert `reset` during a debounce and during RUN → all outputs return to reset values next cycle, and no pulse is issued.
